// File: rtl/amo_exec_unit.sv
// RV32A word-atomic execution stage: runs LR/SC/AMO read-modify-write sequences
// against a single-port data memory and owns the LR/SC reservation.
module amo_exec_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_func5,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_src,
   input  logic [TAG_W-1:0] req_tag,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_we,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_wdata,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic             inv_valid,
   input  logic [XLEN-1:0]  inv_addr,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [XLEN-1:0]  res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err
);

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_SWAP = 5'b00001;
   localparam logic [4:0] F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

   state_t           state_reg;
   logic [4:0]       func_reg;
   logic [XLEN-1:0]  src_reg;
   logic             rsv_valid_reg;
   logic [XLEN-3:0]  rsv_addr_reg;

   function automatic logic is_legal(input logic [4:0] f);
      case (f)
         F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
         F_MIN, F_MAX, F_MINU, F_MAXU: is_legal = 1'b1;
         default:                      is_legal = 1'b0;
      endcase
   endfunction

   // Ties on the min/max ops keep the old value.
   function automatic logic [XLEN-1:0] amo_new(input logic [4:0] f,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] src);
      case (f)
         F_SWAP:  amo_new = src;
         F_ADD:   amo_new = old + src;
         F_XOR:   amo_new = old ^ src;
         F_AND:   amo_new = old & src;
         F_OR:    amo_new = old | src;
         F_MIN:   amo_new = ($signed(src) < $signed(old)) ? src : old;
         F_MAX:   amo_new = ($signed(src) > $signed(old)) ? src : old;
         F_MINU:  amo_new = (src < old) ? src : old;
         F_MAXU:  amo_new = (src > old) ? src : old;
         default: amo_new = old;
      endcase
   endfunction

   logic inv_hit;
   logic sc_hit;
   logic amo_hit;
   logic unused_inv_bits;

   assign inv_hit   = inv_valid && rsv_valid_reg && (inv_addr[XLEN-1:2] == rsv_addr_reg);
   assign sc_hit    = rsv_valid_reg && (rsv_addr_reg == req_addr[XLEN-1:2]) && !inv_hit;
   assign amo_hit   = rsv_valid_reg && (rsv_addr_reg == mem_addr[XLEN-1:2]);
   assign req_ready = (state_reg == IDLE);
   assign unused_inv_bits = ^inv_addr[1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         func_reg      <= '0;
         src_reg       <= '0;
         rsv_valid_reg <= 1'b0;
         rsv_addr_reg  <= '0;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_tag       <= '0;
         res_err       <= 1'b0;
      end else begin
         if (inv_hit)
            rsv_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  func_reg <= req_func5;
                  src_reg  <= req_src;
                  res_tag  <= req_tag;
                  res_err  <= 1'b0;
                  if (req_addr[1:0] != 2'b00 || !is_legal(req_func5)) begin
                     res_err   <= 1'b1;
                     res_data  <= '0;
                     res_valid <= 1'b1;
                     state_reg <= RESP;
                  end else if (req_func5 == F_SC) begin
                     rsv_valid_reg <= 1'b0;
                     if (sc_hit) begin
                        res_data      <= '0;
                        mem_addr      <= {req_addr[XLEN-1:2], 2'b00};
                        mem_wdata     <= req_src;
                        mem_we        <= 1'b1;
                        mem_req_valid <= 1'b1;
                        state_reg     <= WR_REQ;
                     end else begin
                        res_data  <= {{(XLEN-1){1'b0}}, 1'b1};
                        res_valid <= 1'b1;
                        state_reg <= RESP;
                     end
                  end else begin
                     mem_addr      <= {req_addr[XLEN-1:2], 2'b00};
                     mem_we        <= 1'b0;
                     mem_req_valid <= 1'b1;
                     state_reg     <= RD_REQ;
                  end
               end
            end
            RD_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state_reg     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_rvalid) begin
                  res_data <= mem_rdata;
                  if (func_reg == F_LR) begin
                     // Placed after the invalidation clear so a same-cycle LR set wins.
                     rsv_valid_reg <= 1'b1;
                     rsv_addr_reg  <= mem_addr[XLEN-1:2];
                     res_valid     <= 1'b1;
                     state_reg     <= RESP;
                  end else begin
                     mem_wdata     <= amo_new(func_reg, mem_rdata, src_reg);
                     mem_we        <= 1'b1;
                     mem_req_valid <= 1'b1;
                     state_reg     <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  mem_we        <= 1'b0;
                  res_valid     <= 1'b1;
                  if (amo_hit)
                     rsv_valid_reg <= 1'b0;
                  state_reg <= RESP;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_amo_exec_unit.sv
// Directed scoreboard bench for amo_exec_unit: a memory model checks every
// memory operation and a monitor checks every result handshake.
module tb_amo_exec_unit;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [4:0]       req_func5;
   logic [XLEN-1:0]  req_addr;
   logic [XLEN-1:0]  req_src;
   logic [TAG_W-1:0] req_tag;
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic             mem_we;
   logic [XLEN-1:0]  mem_addr;
   logic [XLEN-1:0]  mem_wdata;
   logic             mem_rvalid;
   logic [XLEN-1:0]  mem_rdata;
   logic             inv_valid;
   logic [XLEN-1:0]  inv_addr;
   logic             res_valid;
   logic             res_ready;
   logic [XLEN-1:0]  res_data;
   logic [TAG_W-1:0] res_tag;
   logic             res_err;

   amo_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_func5(req_func5),
      .req_addr(req_addr), .req_src(req_src), .req_tag(req_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .inv_valid(inv_valid), .inv_addr(inv_addr),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_tag(res_tag), .res_err(res_err)
   );

   always #5 clk = ~clk;

   typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} mop_t;
   typedef struct {logic [31:0] data; logic [5:0] tag; logic err;} res_t;

   mop_t exp_mem[$];
   res_t exp_res[$];
   logic [31:0] mem [logic [31:0]];

   int vectors = 0;
   int miscompares = 0;
   int rd_delay = 0;
   int rd_cnt = -1;
   logic [31:0] rd_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic mop_t mk_mop(input logic we, input logic [31:0] a, input logic [31:0] d);
      mop_t m;
      m.we = we; m.addr = a; m.data = d;
      return m;
   endfunction

   // Memory model: checks each accepted request against the expected queue.
   always @(negedge clk) begin
      mop_t m;
      mem_rvalid = 1'b0;
      if (rd_cnt == 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = rd_word;
         rd_cnt     = -1;
      end else if (rd_cnt > 0) begin
         rd_cnt--;
      end
      if (rst_n && mem_req_valid && mem_req_ready) begin
         if (exp_mem.size() == 0) begin
            chk("mem_op_unexpected", {31'd0, mem_we} | 32'h2, 32'h0);
         end else begin
            m = exp_mem.pop_front();
            chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) chk("mem_wdata", mem_wdata, m.data);
         end
         if (mem_we) begin
            mem[mem_addr] = mem_wdata;
         end else begin
            rd_word = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            rd_cnt  = rd_delay;
         end
      end
   end

   // Result monitor and stall-stability checks.
   logic        mstall = 1'b0, rstall = 1'b0;
   logic        pm_we;
   logic [31:0] pm_addr, pm_wdata, pr_data;
   logic [5:0]  pr_tag;
   logic        pr_err;

   always @(negedge clk) begin
      res_t e;
      if (!rst_n) begin
         mstall = 1'b0;
         rstall = 1'b0;
      end else begin
         if (mstall) begin
            chk("mem_stall_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("mem_stall_we", {31'd0, mem_we}, {31'd0, pm_we});
            chk("mem_stall_addr", mem_addr, pm_addr);
            chk("mem_stall_wdata", mem_wdata, pm_wdata);
         end
         mstall = mem_req_valid && !mem_req_ready;
         pm_we = mem_we; pm_addr = mem_addr; pm_wdata = mem_wdata;
         if (rstall) begin
            chk("res_stall_valid", {31'd0, res_valid}, 32'd1);
            chk("res_stall_data", res_data, pr_data);
            chk("res_stall_tag", {26'd0, res_tag}, {26'd0, pr_tag});
            chk("res_stall_err", {31'd0, res_err}, {31'd0, pr_err});
         end
         rstall = res_valid && !res_ready;
         pr_data = res_data; pr_tag = res_tag; pr_err = res_err;
         if (res_valid && res_ready) begin
            $display("result tag %0d data %h err %0d", res_tag, res_data, res_err);
            if (exp_res.size() == 0) begin
               chk("res_unexpected", {31'd0, res_valid}, 32'd0);
            end else begin
               e = exp_res.pop_front();
               chk("res_data", res_data, e.data);
               chk("res_tag", {26'd0, res_tag}, {26'd0, e.tag});
               chk("res_err", {31'd0, res_err}, {31'd0, e.err});
            end
         end
      end
   end

   task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] s,
                        input logic [5:0] t, input logic [31:0] ed, input logic ee,
                        input int lat);
      res_t r;
      int n;
      r.data = ed; r.tag = t; r.err = ee;
      exp_res.push_back(r);
      n = 0;
      @(posedge clk); #2;
      while (!req_ready && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      req_valid = 1'b1; req_func5 = f; req_addr = a; req_src = s; req_tag = t;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (lat > 0) begin
         n = 1;
         while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         chk("latency", n, lat);
      end
      n = 0;
      while (exp_res.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (exp_res.size() != 0) begin
         chk("result_timeout", exp_res.size(), 0);
         exp_res.delete();
      end
   endtask

   task automatic stall_ctl();
      int n;
      n = 0;
      while (!mem_req_valid && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      repeat (3) @(posedge clk);
      #2 mem_req_ready = 1'b1;
      n = 0;
      while (!res_valid && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      repeat (5) @(posedge clk);
      #2 res_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_func5 = '0; req_addr = '0; req_src = '0;
      req_tag = '0; mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
      inv_valid = 1'b0; inv_addr = '0; res_ready = 1'b1;
      mem[32'h100] = 32'd5;
      mem[32'h40]  = 32'hFFFF_FFFF;
      mem[32'h200] = 32'd7;
      mem[32'h300] = 32'h11;
      mem[32'h500] = 32'hF0F0_F0F0;
      mem[32'h600] = 32'd2;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_tag", {26'd0, res_tag}, 32'd0);
      chk("rst_res_err", {31'd0, res_err}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      #1 rst_n = 1'b1;

      // AMO arithmetic and logic ops
      exp_mem.push_back(mk_mop(0, 32'h100, 0)); exp_mem.push_back(mk_mop(1, 32'h100, 32'd8));
      issue(5'b00000, 32'h100, 32'd3, 6'd1, 32'd5, 1'b0, 4);
      exp_mem.push_back(mk_mop(0, 32'h40, 0)); exp_mem.push_back(mk_mop(1, 32'h40, 32'hFFFF_FFFF));
      issue(5'b10000, 32'h40, 32'd1, 6'd2, 32'hFFFF_FFFF, 1'b0, 4);
      exp_mem.push_back(mk_mop(0, 32'h40, 0)); exp_mem.push_back(mk_mop(1, 32'h40, 32'd1));
      issue(5'b11000, 32'h40, 32'd1, 6'd3, 32'hFFFF_FFFF, 1'b0, 4);
      exp_mem.push_back(mk_mop(0, 32'h40, 0)); exp_mem.push_back(mk_mop(1, 32'h40, 32'd1));
      issue(5'b10100, 32'h40, 32'h8000_0000, 6'd4, 32'd1, 1'b0, 4);
      exp_mem.push_back(mk_mop(0, 32'h40, 0)); exp_mem.push_back(mk_mop(1, 32'h40, 32'h8000_0000));
      issue(5'b11100, 32'h40, 32'h8000_0000, 6'd5, 32'd1, 1'b0, 4);
      exp_mem.push_back(mk_mop(0, 32'h40, 0)); exp_mem.push_back(mk_mop(1, 32'h40, 32'h1234_5678));
      issue(5'b00001, 32'h40, 32'h1234_5678, 6'd6, 32'h8000_0000, 1'b0, 4);
      exp_mem.push_back(mk_mop(0, 32'h40, 0)); exp_mem.push_back(mk_mop(1, 32'h40, 32'h0000_5678));
      issue(5'b01100, 32'h40, 32'h0000_FFFF, 6'd7, 32'h1234_5678, 1'b0, 4);
      exp_mem.push_back(mk_mop(0, 32'h40, 0)); exp_mem.push_back(mk_mop(1, 32'h40, 32'hAB00_5678));
      issue(5'b01000, 32'h40, 32'hAB00_0000, 6'd8, 32'h0000_5678, 1'b0, 4);

      // LR / SC success, then SC without reservation
      exp_mem.push_back(mk_mop(0, 32'h200, 0));
      issue(5'b00010, 32'h200, 32'd0, 6'd9, 32'd7, 1'b0, 3);
      exp_mem.push_back(mk_mop(1, 32'h200, 32'd9));
      issue(5'b00011, 32'h200, 32'd9, 6'd10, 32'd0, 1'b0, 2);
      issue(5'b00011, 32'h200, 32'd9, 6'd11, 32'd1, 1'b0, 1);

      // Invalidation kills the reservation
      exp_mem.push_back(mk_mop(0, 32'h300, 0));
      issue(5'b00010, 32'h300, 32'd0, 6'd12, 32'h11, 1'b0, 3);
      @(posedge clk); #2 inv_valid = 1'b1; inv_addr = 32'h300;
      @(posedge clk); #2 inv_valid = 1'b0;
      issue(5'b00011, 32'h300, 32'd5, 6'd13, 32'd1, 1'b0, 1);

      // AMO write to the reserved word kills the reservation
      exp_mem.push_back(mk_mop(0, 32'h600, 0));
      issue(5'b00010, 32'h600, 32'd0, 6'd14, 32'd2, 1'b0, 3);
      exp_mem.push_back(mk_mop(0, 32'h600, 0)); exp_mem.push_back(mk_mop(1, 32'h600, 32'd3));
      issue(5'b00000, 32'h600, 32'd1, 6'd15, 32'd2, 1'b0, 4);
      issue(5'b00011, 32'h600, 32'd4, 6'd16, 32'd1, 1'b0, 1);

      // Errors: misaligned and illegal funct5
      issue(5'b00001, 32'h102, 32'd1, 6'd17, 32'd0, 1'b1, 1);
      issue(5'b11111, 32'h100, 32'd1, 6'd18, 32'd0, 1'b1, 1);

      // Back-pressure on memory and writeback during AMOXOR
      @(posedge clk); #2 mem_req_ready = 1'b0; res_ready = 1'b0;
      exp_mem.push_back(mk_mop(0, 32'h500, 0)); exp_mem.push_back(mk_mop(1, 32'h500, 32'h0F0F_F0F0));
      fork
         issue(5'b00100, 32'h500, 32'hFFFF_0000, 6'd19, 32'hF0F0_F0F0, 1'b0, -1);
         stall_ctl();
      join

      // Reset during RD_WAIT aborts the operation
      rd_delay = 6;
      exp_mem.push_back(mk_mop(0, 32'h100, 0));
      @(posedge clk); #2;
      req_valid = 1'b1; req_func5 = 5'b00000; req_addr = 32'h100; req_src = 32'd1; req_tag = 6'd20;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("abort_quiet", {30'd0, res_valid, mem_req_valid}, 32'd0);
      end
      rd_delay = 0;

      chk("mem_ops_left", exp_mem.size(), 0);
      chk("results_left", exp_res.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
